dac_multi_channel_sender: RTL and testbench

- Parametrised successor to the stereo DAC output stage.
- Accepts NUM_CH signed samples per frame and conditions each one: scale, optional mix or ring-mod, clamp, then offset to unsigned DAC code.
- Sends each channel as a framed SPI word to the external DAC SPI serialiser via a send/ready handshake.
- Sits between the additive oscillator mixer and the DAC SPI serialiser.

---
 rtl/dac_out_pkg.sv | 24 ++
 rtl/dac_multi_channel_sender_if.sv | 26 ++
 rtl/dac_sample_conditioner.sv | 69 ++++++
 rtl/dac_multi_channel_sender.sv | 194 +++++++++++++++++++
 tb/tb_dac_multi_channel_sender.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_out_pkg.sv
// Shared types for the multi-channel DAC output stage: sequencer states, mode codes
// and the mid-scale offset helper.
package dac_out_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MIX,
        CLAMP,
        RING,
        OFFSET,
        SEND,
        ACK,
        DONE
    } state_t;

    localparam logic [1:0] MODE_DIRECT = 2'd0;
    localparam logic [1:0] MODE_MIX    = 2'd1;
    localparam logic [1:0] MODE_RING   = 2'd2;

    function automatic int dac_offset(input int dac_bits);
        return (1 << (dac_bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/dac_multi_channel_sender_if.sv
// Frame input and serialiser handshake bundle of the multi-channel DAC sender.
// slave = the sender itself, master = the mixer/serialiser side driving it.
interface dac_multi_channel_sender_if #(
    parameter int NUM_CH   = 2,
    parameter int IN_WIDTH = 32,
    parameter int DAC_BITS = 16,
    parameter int CMD_BITS = 8
);
    logic                         i_Start;
    logic [NUM_CH*IN_WIDTH-1:0]   i_Samples;
    logic [1:0]                   i_Mode;
    logic                         i_DAC_Ready;
    logic [CMD_BITS+DAC_BITS-1:0] o_Data;
    logic                         o_Send;
    logic                         o_Busy;

    modport master (
        output i_Start, i_Samples, i_Mode, i_DAC_Ready,
        input  o_Data, o_Send, o_Busy
    );

    modport slave (
        input  i_Start, i_Samples, i_Mode, i_DAC_Ready,
        output o_Data, o_Send, o_Busy
    );
endinterface

// File: rtl/dac_sample_conditioner.sv
// One channel of the sender datapath: saturating capture, external load, clamp, offset.
// With DAC_CLIP_DETECT_EN defined it also reports when the clamp altered the sample.
module dac_sample_conditioner
    import dac_out_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    parameter int DAC_BITS = 16,
    parameter int IN_SHIFT = 2,
    localparam int W = DAC_BITS + 4
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Capture,
    input  logic signed [IN_WIDTH-1:0] i_Sample,
    input  logic                       i_Load,
    input  logic signed [W-1:0]        i_Load_Value,
    input  logic                       i_Clamp,
    input  logic                       i_Offset,
`ifdef DAC_CLIP_DETECT_EN
    output logic                       o_Clamped,
`endif
    output logic signed [W-1:0]        o_Value
);
    localparam int OFFSET_CODE = dac_offset(DAC_BITS);
    localparam logic signed [W-1:0] POS_LIM = W'(OFFSET_CODE);
    localparam logic signed [W-1:0] NEG_LIM = -POS_LIM;
    localparam logic signed [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [IN_WIDTH-1:0] IN_MAX = IN_WIDTH'(W_MAX);
    localparam logic signed [IN_WIDTH-1:0] IN_MIN = IN_WIDTH'(W_MIN);

    logic signed [IN_WIDTH-1:0] shifted;
    logic signed [W-1:0]        captured;
    logic signed [W-1:0]        clamped;
    logic                       over;
    logic                       under;

    always_comb begin
        shifted = i_Sample >>> IN_SHIFT;
        if (shifted > IN_MAX)
            captured = W_MAX;
        else if (shifted < IN_MIN)
            captured = W_MIN;
        else
            captured = shifted[W-1:0];
        over    = (o_Value > POS_LIM);
        under   = (o_Value < NEG_LIM);
        clamped = over ? POS_LIM : (under ? NEG_LIM : o_Value);
    end

    // After the clamp the value lies in +/-OFFSET, so adding OFFSET cannot leave 0..2*OFFSET.
    always_ff @(posedge i_Clock) begin
        if (i_Reset)
            o_Value <= '0;
        else if (i_Capture)
            o_Value <= captured;
        else if (i_Load)
            o_Value <= i_Load_Value;
        else if (i_Clamp)
            o_Value <= clamped;
        else if (i_Offset)
            o_Value <= o_Value + POS_LIM;
    end

`ifdef DAC_CLIP_DETECT_EN
    assign o_Clamped = i_Clamp && (over || under);
`endif

endmodule

// File: rtl/dac_multi_channel_sender.sv
// Conditions NUM_CH signed samples per frame and sends each as a {prefix, code} SPI word.
// Optional sticky per-channel clip flags are built when DAC_CLIP_DETECT_EN is defined.
module dac_multi_channel_sender
    import dac_out_pkg::*;
#(
    parameter int                NUM_CH   = 2,
    parameter int                IN_WIDTH = 32,
    parameter int                DAC_BITS = 16,
    parameter int                IN_SHIFT = 2,
    parameter int                CMD_BITS = 8,
    parameter logic [CMD_BITS-1:0] CMD_BASE = 8'h31
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
`ifdef DAC_CLIP_DETECT_EN
    input  logic                      i_Clip_Clear,
    output logic [NUM_CH-1:0]         o_Clip,
`endif
    dac_multi_channel_sender_if.slave bus
);
    // state  | meaning
    // IDLE   | waiting for i_Start with the serialiser ready
    // MIX    | ch0 <= saturated sum of all channels
    // CLAMP  | every channel limited to +/-OFFSET
    // RING   | last channel <= (ch0*ch1) >>> (DAC_BITS-1)
    // OFFSET | every channel shifted to unsigned DAC code
    // SEND   | o_Data <= word for channel idx, raise o_Send
    // ACK    | hold o_Send until the serialiser drops ready
    // DONE   | wait for ready, then next channel or back to IDLE

    localparam int W      = DAC_BITS + 4;
    localparam int IDX_W  = $clog2(NUM_CH);
    localparam int SUM_W  = W + IDX_W;
    localparam logic signed [W-1:0]     W_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]     W_MIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(W_MAX);
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(W_MIN);

    state_t                       state, state_next;
    logic [IDX_W-1:0]             idx, idx_next;
    logic [1:0]                   mode_q, mode_next;
    logic                         send_q, send_next;
    logic                         busy_q, busy_next;
    logic [CMD_BITS+DAC_BITS-1:0] data_q, data_next;
    logic                         capture, mix_load, clamp_en, ring_load, offset_en;

    logic signed [W-1:0]          ch_val [NUM_CH];
    logic signed [SUM_W-1:0]      mix_sum;
    logic                         mix_hi, mix_lo;
    logic signed [W-1:0]          mix_val;
    logic signed [2*W-1:0]        ring_prod;
    logic signed [W-1:0]          ring_val;
`ifdef DAC_CLIP_DETECT_EN
    logic [NUM_CH-1:0]            ch_clamped;
    logic [NUM_CH-1:0]            clip_set;
`endif

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_CH; i++)
            mix_sum = mix_sum + SUM_W'(ch_val[i]);
    end

    assign mix_hi    = (mix_sum > SUM_MAX);
    assign mix_lo    = (mix_sum < SUM_MIN);
    assign mix_val   = mix_hi ? W_MAX : (mix_lo ? W_MIN : mix_sum[W-1:0]);
    // Operands are already clamped, so the shifted product stays inside +/-OFFSET.
    assign ring_prod = ch_val[0] * ch_val[1];
    assign ring_val  = W'(ring_prod >>> (DAC_BITS - 1));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dac_sample_conditioner #(
            .IN_WIDTH (IN_WIDTH),
            .DAC_BITS (DAC_BITS),
            .IN_SHIFT (IN_SHIFT)
        ) u_cond (
            .i_Clock      (i_Clock),
            .i_Reset      (i_Reset),
            .i_Capture    (capture),
            .i_Sample     (bus.i_Samples[g*IN_WIDTH +: IN_WIDTH]),
            .i_Load       (((g == 0) && mix_load) || ((g == NUM_CH - 1) && ring_load)),
            .i_Load_Value ((g == 0) ? mix_val : ring_val),
            .i_Clamp      (clamp_en),
            .i_Offset     (offset_en),
`ifdef DAC_CLIP_DETECT_EN
            .o_Clamped    (ch_clamped[g]),
`endif
            .o_Value      (ch_val[g])
        );
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        mode_next  = mode_q;
        send_next  = send_q;
        busy_next  = busy_q;
        data_next  = data_q;
        capture    = 1'b0;
        mix_load   = 1'b0;
        clamp_en   = 1'b0;
        ring_load  = 1'b0;
        offset_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.i_Start && bus.i_DAC_Ready) begin
                    capture    = 1'b1;
                    mode_next  = bus.i_Mode;
                    busy_next  = 1'b1;
                    idx_next   = '0;
                    state_next = (bus.i_Mode == MODE_MIX) ? MIX : CLAMP;
                end
            end
            MIX: begin
                mix_load   = 1'b1;
                state_next = CLAMP;
            end
            CLAMP: begin
                clamp_en   = 1'b1;
                state_next = ((mode_q == MODE_RING) && (NUM_CH >= 2)) ? RING : OFFSET;
            end
            RING: begin
                ring_load  = 1'b1;
                state_next = OFFSET;
            end
            OFFSET: begin
                offset_en  = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                data_next  = {CMD_BASE + CMD_BITS'(idx), ch_val[idx][DAC_BITS-1:0]};
                send_next  = 1'b1;
                state_next = ACK;
            end
            ACK: begin
                if (!bus.i_DAC_Ready) begin
                    send_next  = 1'b0;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.i_DAC_Ready) begin
                    if (idx == IDX_W'(NUM_CH - 1)) begin
                        idx_next   = '0;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx + 1'b1;
                        state_next = SEND;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state  <= IDLE;
            idx    <= '0;
            mode_q <= MODE_DIRECT;
            send_q <= 1'b0;
            busy_q <= 1'b0;
            data_q <= '0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            mode_q <= mode_next;
            send_q <= send_next;
            busy_q <= busy_next;
            data_q <= data_next;
        end
    end

    assign bus.o_Send = send_q;
    assign bus.o_Busy = busy_q;
    assign bus.o_Data = data_q;

`ifdef DAC_CLIP_DETECT_EN
    always_comb begin
        clip_set    = ch_clamped;
        clip_set[0] = ch_clamped[0] | (mix_load & (mix_hi | mix_lo));
    end

    // A new clip event in the same cycle as a clear is kept.
    always_ff @(posedge i_Clock) begin
        if (i_Reset)
            o_Clip <= '0;
        else
            o_Clip <= (o_Clip & {NUM_CH{~i_Clip_Clear}}) | clip_set;
    end
`endif

endmodule

// File: tb/tb_dac_multi_channel_sender.sv
// Self-checking bench for dac_multi_channel_sender: directed frames plus randomized frames
// checked against an integer reference model of the conditioning chain.
module tb_dac_multi_channel_sender;
    localparam int NCH = 2;
    localparam int IW  = 32;
    localparam int DB  = 16;
    localparam int CB  = 8;
    localparam longint W_HI = 524287;
    localparam longint W_LO = -524288;
    localparam longint LIM  = 32767;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dac_multi_channel_sender_if #(.NUM_CH(NCH), .IN_WIDTH(IW), .DAC_BITS(DB), .CMD_BITS(CB)) bus ();

`ifdef DAC_CLIP_DETECT_EN
    logic [NCH-1:0] clip;
`endif

    dac_multi_channel_sender #(
        .NUM_CH   (NCH),
        .IN_WIDTH (IW),
        .DAC_BITS (DB),
        .IN_SHIFT (2),
        .CMD_BITS (CB),
        .CMD_BASE (8'h31)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
`ifdef DAC_CLIP_DETECT_EN
        .i_Clip_Clear (1'b0),
        .o_Clip       (clip),
`endif
        .bus          (bus)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    int     send_cnt = 0;
    logic   send_d   = 1'b0;
    longint exp_code [NCH];

    always @(negedge clk) begin
        if (bus.o_Send && !send_d)
            send_cnt = send_cnt + 1;
        send_d = bus.o_Send;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint lo, input longint hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic longint model_code(input logic [NCH*IW-1:0] s, input logic [1:0] m, input int k);
        longint v [NCH];
        longint acc = 0;
        for (int i = 0; i < NCH; i++)
            v[i] = sat(longint'($signed(s[i*IW +: IW])) >>> 2, W_LO, W_HI);
        if (m == 2'd1) begin
            for (int i = 0; i < NCH; i++)
                acc += v[i];
            v[0] = sat(acc, W_LO, W_HI);
        end
        for (int i = 0; i < NCH; i++)
            v[i] = sat(v[i], -LIM, LIM);
        if (m == 2'd2)
            v[NCH-1] = (v[0] * v[1]) >>> 15;
        return v[k] + LIM;
    endfunction

    function automatic logic [IW-1:0] rand_sample();
        logic [IW-1:0] r;
        case ($urandom_range(0, 3))
            0:       r = $urandom;
            1:       r = 32'($urandom_range(0, 400000)) - 32'd200000;
            2:       r = 32'($urandom_range(0, 1 << 23)) - 32'(1 << 22);
            default: r = 32'($urandom_range(0, 8));
        endcase
        return r;
    endfunction

    task automatic run_frame(input logic [NCH*IW-1:0] s, input logic [1:0] m,
                             input bit poke_start, input int low_hold);
        int start_cnt;
        int w;
        start_cnt     = send_cnt;
        bus.i_Samples = s;
        bus.i_Mode    = m;
        bus.i_Start   = 1'b1;
        @(negedge clk);
        bus.i_Start = 1'b0;
        check_eq("busy_set", longint'(bus.o_Busy), 1);
        for (int k = 0; k < NCH; k++) begin
            w = 0;
            while (!bus.o_Send && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (k == 0)
                check_eq("latency", 1 + w, (m == 2'd1 || m == 2'd2) ? 5 : 4);
            check_eq($sformatf("send_seen_ch%0d", k), longint'(bus.o_Send), 1);
            check_eq($sformatf("data_ch%0d", k), longint'(bus.o_Data),
                     longint'(8'h31 + k) * 65536 + exp_code[k]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (poke_start) begin
                bus.i_Start = 1'b1;
                @(negedge clk);
                bus.i_Start = 1'b0;
            end
            check_eq("send_hold", longint'(bus.o_Send), 1);
            bus.i_DAC_Ready = 1'b0;
            @(negedge clk);
            check_eq("send_drop", longint'(bus.o_Send), 0);
            repeat (low_hold) @(negedge clk);
            if (low_hold >= 50) begin
                check_eq("send_low_hold", longint'(bus.o_Send), 0);
                check_eq("busy_low_hold", longint'(bus.o_Busy), 1);
            end
            bus.i_DAC_Ready = 1'b1;
            @(negedge clk);
        end
        w = 0;
        while (bus.o_Busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_eq("busy_clear", longint'(bus.o_Busy), 0);
        repeat (6) @(negedge clk);
        check_eq("send_count", send_cnt - start_cnt, NCH);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH*IW-1:0] s;
        logic [1:0]        m;
        int                start_cnt;
        int                w;

        rst             = 1'b1;
        bus.i_Start     = 1'b0;
        bus.i_Samples   = '0;
        bus.i_Mode      = 2'd0;
        bus.i_DAC_Ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_send", longint'(bus.o_Send), 0);
        check_eq("rst_data", longint'(bus.o_Data), 0);
        check_eq("rst_busy", longint'(bus.o_Busy), 0);
        rst = 1'b0;
        @(negedge clk);

        s = '0;
        exp_code[0] = 'h7FFF; exp_code[1] = 'h7FFF;
        run_frame(s, 2'd0, 1'b0, 2);

        s[31:0] = 32'h0010_0000; s[63:32] = 32'hFFF0_0000;
        exp_code[0] = 'hFFFE; exp_code[1] = 'h0000;
        run_frame(s, 2'd0, 1'b0, 1);

        s[31:0] = 32'd80000; s[63:32] = 32'd80000;
        exp_code[0] = 'hFFFE; exp_code[1] = 'hCE1F;
        run_frame(s, 2'd1, 1'b0, 0);

        s[31:0] = 32'd65536; s[63:32] = 32'd65536;
        exp_code[0] = 'hBFFF; exp_code[1] = 'h9FFF;
        run_frame(s, 2'd2, 1'b0, 3);

        s[31:0] = 32'd4000; s[63:32] = -32'sd4000;
        exp_code[0] = 'h83E7; exp_code[1] = 'h7C17;
        run_frame(s, 2'd3, 1'b0, 0);

        s = '0;
        exp_code[0] = 'h7FFF; exp_code[1] = 'h7FFF;
        run_frame(s, 2'd0, 1'b1, 50);

        start_cnt       = send_cnt;
        bus.i_DAC_Ready = 1'b0;
        bus.i_Start     = 1'b1;
        @(negedge clk);
        bus.i_Start = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("notready_busy", longint'(bus.o_Busy), 0);
        check_eq("notready_sends", send_cnt - start_cnt, 0);
        bus.i_DAC_Ready = 1'b1;
        @(negedge clk);

        start_cnt     = send_cnt;
        bus.i_Samples = '0;
        bus.i_Mode    = 2'd0;
        bus.i_Start   = 1'b1;
        @(negedge clk);
        bus.i_Start = 1'b0;
        w = 0;
        while (!bus.o_Send && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("rstmid_first_data", longint'(bus.o_Data), 'h317FFF);
        bus.i_DAC_Ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstmid_send", longint'(bus.o_Send), 0);
        check_eq("rstmid_busy", longint'(bus.o_Busy), 0);
        rst             = 1'b0;
        bus.i_DAC_Ready = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("rstmid_no_more_sends", send_cnt - start_cnt, 1);

        s[31:0] = 32'd4000; s[63:32] = -32'sd4000;
        exp_code[0] = 'h83E7; exp_code[1] = 'h7C17;
        run_frame(s, 2'd0, 1'b0, 0);

        for (int f = 0; f < 24; f++) begin
            for (int c = 0; c < NCH; c++)
                s[c*IW +: IW] = rand_sample();
            m = 2'($urandom_range(0, 3));
            for (int c = 0; c < NCH; c++)
                exp_code[c] = model_code(s, m, c);
            run_frame(s, m, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
